// File: rtl/circular_arc_stepper_pkg.sv
// Shared types and constants for the circular arc stepper.
package circular_arc_stepper_pkg;

  localparam int BYTE_BITS = 8;
  localparam int STEP_OFS  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_EMIT,
    S_DONE
  } state_e;

  typedef logic signed [1:0] dir_t;

endpackage

// File: rtl/circular_arc_stepper_chooser.sv
// Picks the next unit step of the circle walk
// and the error term it leaves behind.
module circular_arc_stepper_chooser
  import circular_arc_stepper_pkg::*;
#(
  parameter  int NUM_BITS = BYTE_BITS,
  localparam int EW       = 2*NUM_BITS+3
) (
  input  logic signed [NUM_BITS-1:0] x,
  input  logic signed [NUM_BITS-1:0] y,
  input  logic signed [EW-1:0]       err,
  input  logic                       is_cw,
  output logic signed [1:0]          step_x,
  output logic signed [1:0]          step_y,
  output logic signed [EW-1:0]       err_nxt
);

  dir_t sgn_x, sgn_y, sx, sy;
  logic signed [EW-1:0] xe, ye, tx, ty;
  logic signed [EW-1:0] ex, ey, ax, ay;
  logic use_y0, use_x, use_y1;

  always_comb begin
    sgn_x = (x == '0) ? 2'sb00 :
            (x[NUM_BITS-1] ? 2'sb11 : 2'sb01);
    sgn_y = (y == '0) ? 2'sb00 :
            (y[NUM_BITS-1] ? 2'sb11 : 2'sb01);
    sx = is_cw ? sgn_y : dir_t'(-sgn_y);
    sy = is_cw ? dir_t'(-sgn_x) : sgn_x;

    xe = {{(EW-NUM_BITS){x[NUM_BITS-1]}}, x};
    ye = {{(EW-NUM_BITS){y[NUM_BITS-1]}}, y};
    tx = '0;
    ty = '0;
    if (sx == 2'sb01) tx = xe + xe;
    if (sx == 2'sb11) tx = -(xe + xe);
    if (sy == 2'sb01) ty = ye + ye;
    if (sy == 2'sb11) ty = -(ye + ye);

    ex = err + tx + EW'(1);
    ey = err + ty + EW'(1);
    ax = ex[EW-1] ? -ex : ex;
    ay = ey[EW-1] ? -ey : ey;

    // ties favour the x-axis step
    use_y0 = (sx == 2'sb00);
    use_x  = !use_y0 &&
             ((sy == 2'sb00) || (ax <= ay));
    use_y1 = !use_y0 && !use_x;

    step_x  = 2'sb00;
    step_y  = 2'sb00;
    err_nxt = ey;
    unique case (1'b1)
      use_y0: begin
        step_y  = sy;
        err_nxt = ey;
      end
      use_x: begin
        step_x  = sx;
        err_nxt = ex;
      end
      use_y1: begin
        step_y  = sy;
        err_nxt = ey;
      end
      default: begin
        step_y  = sy;
        err_nxt = ey;
      end
    endcase
  end

endmodule

// File: rtl/circular_arc_stepper.sv
// Arc step generator: FSM, registers and step handshake.
// Define CIRCULAR_ARC_STEPPER_POS_OUT_EN to expose pos_x/pos_y.
module circular_arc_stepper
  import circular_arc_stepper_pkg::*;
#(
  parameter  int NUM_BITS  = BYTE_BITS,
  localparam int STEP_BITS = NUM_BITS + STEP_OFS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_cw,
  input  logic [NUM_BITS-1:0]  start_x,
  input  logic [NUM_BITS-1:0]  start_y,
  input  logic [NUM_BITS-1:0]  r,
  input  logic [STEP_BITS-1:0] num_steps,
  output logic                 step_valid,
  input  logic                 step_ready,
  output logic [1:0]           step_x,
  output logic [1:0]           step_y,
  output logic                 done
`ifdef CIRCULAR_ARC_STEPPER_POS_OUT_EN
  ,
  output logic [NUM_BITS-1:0]  pos_x,
  output logic [NUM_BITS-1:0]  pos_y
`endif
);

  localparam int EW = 2*NUM_BITS+3;

  state_e state_q, state_d;
  logic cw_q, cw_d;
  logic signed [NUM_BITS-1:0] x_q, x_d;
  logic signed [NUM_BITS-1:0] y_q, y_d;
  logic [NUM_BITS-1:0] r_q, r_d;
  logic [STEP_BITS-1:0] cnt_q, cnt_d;
  logic signed [EW-1:0] err_q, err_d;
  logic signed [EW-1:0] en_q, en_d;
  logic signed [1:0] sx_q, sx_d;
  logic signed [1:0] sy_q, sy_d;

  logic signed [1:0] ch_sx, ch_sy;
  logic signed [EW-1:0] ch_err;
  logic signed [EW-1:0] xe, ye, re, init_err;
  logic signed [NUM_BITS-1:0] dx, dy;

  circular_arc_stepper_chooser #(
    .NUM_BITS(NUM_BITS)
  ) u_chooser (
    .x      (x_q),
    .y      (y_q),
    .err    (err_q),
    .is_cw  (cw_q),
    .step_x (ch_sx),
    .step_y (ch_sy),
    .err_nxt(ch_err)
  );

  always_comb begin
    xe = {{(EW-NUM_BITS){x_q[NUM_BITS-1]}}, x_q};
    ye = {{(EW-NUM_BITS){y_q[NUM_BITS-1]}}, y_q};
    re = {{(EW-NUM_BITS){1'b0}}, r_q};
    init_err = xe*xe + ye*ye - re*re;
    dx = {{(NUM_BITS-2){sx_q[1]}}, sx_q};
    dy = {{(NUM_BITS-2){sy_q[1]}}, sy_q};
  end

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    en_d    = en_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cw_d    = is_cw;
          x_d     = start_x;
          y_d     = start_y;
          r_d     = r;
          cnt_d   = num_steps;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        err_d = init_err;
        if (cnt_q == '0 ||
            (x_q == '0 && y_q == '0))
          state_d = S_DONE;
        else
          state_d = S_CALC;
      end
      S_CALC: begin
        sx_d    = ch_sx;
        sy_d    = ch_sy;
        en_d    = ch_err;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (step_ready) begin
          x_d   = x_q + dx;
          y_d   = y_q + dy;
          err_d = en_q;
          cnt_d = cnt_q - STEP_BITS'(1);
          if (cnt_q == STEP_BITS'(1))
            state_d = S_DONE;
          else
            state_d = S_CALC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cw_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      en_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      en_q    <= en_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign step_valid = (state_q == S_EMIT);
  assign done       = (state_q == S_DONE);
  assign step_x     = sx_q;
  assign step_y     = sy_q;

`ifdef CIRCULAR_ARC_STEPPER_POS_OUT_EN
  assign pos_x = x_q;
  assign pos_y = y_q;
`endif

endmodule

// File: tb/tb_circular_arc_stepper.sv
// Self-checking bench for circular_arc_stepper: vector table,
// hand sequences and random arcs against a behavioural model.
module tb_circular_arc_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       is_cw;
  logic [7:0] start_x, start_y, r;
  logic [10:0] num_steps;
  logic       step_valid;
  logic       step_ready;
  logic [1:0] step_x, step_y;
  logic       done;
`ifdef CIRCULAR_ARC_STEPPER_POS_OUT_EN
  logic [7:0] pos_x, pos_y;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  circular_arc_stepper dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_cw     (is_cw),
    .start_x   (start_x),
    .start_y   (start_y),
    .r         (r),
    .num_steps (num_steps),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .step_x    (step_x),
    .step_y    (step_y),
    .done      (done)
`ifdef CIRCULAR_ARC_STEPPER_POS_OUT_EN
    ,
    .pos_x     (pos_x),
    .pos_y     (pos_y)
`endif
  );

  typedef struct {
    bit cw;
    int x0, y0, r0, n;
    int mode;
    bit chk_fin;
    int fx, fy;
    int dx0, dy0;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int isqrt(input int v);
    int s = 0;
    while ((s+1)*(s+1) <= v) s++;
    return s;
  endfunction

  // One move of the midpoint circle walk, straight from the rules.
  task automatic model_step(input int x, input int y, input int err,
                            input bit cw, output int dx, output int dy,
                            output int en);
    int sx, sy, ex, ey;
    sx = cw ? sgn(y) : -sgn(y);
    sy = cw ? -sgn(x) : sgn(x);
    ex = err + 2*sx*x + 1;
    ey = err + 2*sy*y + 1;
    if (sx == 0) begin
      dx = 0; dy = sy; en = ey;
    end else if (sy == 0 || iabs(ex) <= iabs(ey)) begin
      dx = sx; dy = 0; en = ex;
    end else begin
      dx = 0; dy = sy; en = ey;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: 5-cycle stall on step 2
  task automatic run_arc(input bit cw, input int x0, input int y0,
                         input int r0, input int n, input int mode,
                         output int fx, output int fy, output int nst,
                         output int fdx, output int fdy);
    int mx, my, merr, mcnt;
    int dx, dy, en;
    int cyc, last_acc, stall;
    bit pend, fin, rdy;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid  = 1'b1;
    is_cw     = cw;
    start_x   = 8'(x0);
    start_y   = 8'(y0);
    r         = 8'(r0);
    num_steps = 11'(n);
    step_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mx = x0; my = y0;
    merr = x0*x0 + y0*y0 - r0*r0;
    mcnt = (x0 == 0 && y0 == 0) ? 0 : n;
    nst = 0; cyc = 0; last_acc = -1;
    pend = 0; fin = 0; stall = 0;
    fdx = 0; fdy = 0; dx = 0; dy = 0; en = 0;
    while (!fin && cyc < 8*n + 60) begin
      @(negedge clk);
      cyc++;
      if (mode == 1) begin
        in_valid  = 1'($urandom);
        is_cw     = 1'($urandom);
        start_x   = 8'($urandom);
        num_steps = 11'($urandom);
      end
      if (done) begin
        in_valid = 1'b0;
        fin = 1;
        chk("done_time", cyc, (last_acc < 0) ? 2 : last_acc + 1);
        chk("steps_total", nst, mcnt);
      end else if (step_valid) begin
        if (nst >= mcnt) begin
          chk("extra_step", 1, 0);
          fin = 1;
        end else begin
          if (pend) begin
            chk("hold_x", int'($signed(step_x)), dx);
            chk("hold_y", int'($signed(step_y)), dy);
          end else begin
            model_step(mx, my, merr, cw, dx, dy, en);
            chk("step_x", int'($signed(step_x)), dx);
            chk("step_y", int'($signed(step_y)), dy);
            chk("one_axis", iabs(int'($signed(step_x))) +
                            iabs(int'($signed(step_y))), 1);
            if (nst == 0) begin fdx = dx; fdy = dy; end
            if (mode == 0) chk("step_time", cyc, 3 + 2*nst);
            if (mode == 2 && nst == 2) stall = 5;
          end
          if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
          else rdy = (stall == 0);
          if (stall > 0) stall--;
          step_ready = rdy;
          if (rdy) begin
            mx += dx; my += dy; merr = en;
            nst++; last_acc = cyc; pend = 0;
          end else begin
            pend = 1;
          end
        end
      end else if (pend) begin
        chk("valid_held", 0, 1);
        pend = 0;
      end
    end
    in_valid = 1'b0;
    step_ready = 1'b1;
    if (!fin) begin
      chk("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("done_width", done, 0);
      chk("ready_after_done", in_ready, 1);
`ifdef CIRCULAR_ARC_STEPPER_POS_OUT_EN
      chk("pos_x", int'($signed(pos_x)), mx);
      chk("pos_y", int'($signed(pos_y)), my);
`endif
    end
    fx = mx; fy = my;
  endtask

  initial begin
    int fx, fy, nst, fdx, fdy, ndone, rr, xx, yy, nn;
    bit cw;
    vecs[0] = '{0, 2, 0, 2, 4, 0, 1, 0, 2, 0, 1};
    vecs[1] = '{1, 2, 0, 2, 4, 0, 1, 0, -2, 0, -1};
    vecs[2] = '{0, 0, 2, 2, 16, 0, 1, 0, 2, -1, 0};
    vecs[3] = '{0, 2, 0, 2, 4, 2, 1, 0, 2, 0, 1};
    vecs[4] = '{0, 3, 4, 5, 0, 0, 1, 3, 4, 0, 0};
    vecs[5] = '{1, 0, 0, 5, 5, 0, 1, 0, 0, 0, 0};

    reset = 1'b0; in_valid = 1'b0; is_cw = 1'b0;
    start_x = '0; start_y = '0; r = '0; num_steps = '0;
    step_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_step_valid", step_valid, 0);
    chk("rst_step_x", int'(step_x), 0);
    chk("rst_step_y", int'(step_y), 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_arc(vecs[i].cw, vecs[i].x0, vecs[i].y0, vecs[i].r0,
              vecs[i].n, vecs[i].mode, fx, fy, nst, fdx, fdy);
      if (vecs[i].chk_fin) begin
        chk($sformatf("vec%0d_fx", i), fx, vecs[i].fx);
        chk($sformatf("vec%0d_fy", i), fy, vecs[i].fy);
      end
      chk($sformatf("vec%0d_dx0", i), fdx, vecs[i].dx0);
      chk($sformatf("vec%0d_dy0", i), fdy, vecs[i].dy0);
      chk($sformatf("vec%0d_nst", i), nst,
          (vecs[i].x0 == 0 && vecs[i].y0 == 0) ? 0 : vecs[i].n);
    end

    // reset in the middle of a 4-step arc, during step 3
    @(negedge clk);
    in_valid = 1'b1; is_cw = 1'b0;
    start_x = 8'd2; start_y = 8'd0; r = 8'd2; num_steps = 11'd4;
    step_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_valid", step_valid, 1);
    chk("pre_rst_step_y", int'($signed(step_y)), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", step_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_step_y", int'(step_y), 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    run_arc(0, 2, 0, 2, 4, 0, fx, fy, nst, fdx, fdy);
    chk("post_rst_fx", fx, 0);
    chk("post_rst_fy", fy, 2);

    for (int k = 0; k < 30; k++) begin
      rr = $urandom_range(1, 20);
      xx = $urandom_range(0, rr);
      yy = isqrt(rr*rr - xx*xx);
      if ($urandom_range(0, 1) == 1) xx = -xx;
      if ($urandom_range(0, 1) == 1) yy = -yy;
      nn = $urandom_range(0, 8*rr);
      cw = 1'($urandom);
      run_arc(cw, xx, yy, rr, nn, 1, fx, fy, nst, fdx, fdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
